hls_run_sequencer: RTL and testbench

- Host-side controller that sequences one Bambu-generated HLS accelerator (the `main` top with slave RAM ports).
- Accepts WRITE, READ and RUN commands on a valid/ready command port.
- WRITE/READ go through the accelerator's slave memory channel 0. RUN pulses start_port, counts cycles until done_port and enforces a timeout.
- Sits between the test/host logic and the accelerator, replacing the ad-hoc start/done sequencing of the simulation benches.

---
 rtl/hls_run_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_hls_run_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hls_run_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : hls_run_sequencer
//  Description : Host-side command sequencer for one HLS accelerator. Serves
//                WRITE/READ through slave memory channel 0 and RUN through
//                the start/done handshake with cycle counting and timeouts.
//  Revision    : 1.0 - initial release
// ============================================================================
module hls_run_sequencer #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SIZE_W      = 4,
  parameter int CNT_W       = 32,
  parameter int RUN_TIMEOUT = 200000000,
  parameter int RD_TIMEOUT  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [CNT_W-1:0]      rsp_data,
  output logic [1:0]            rsp_status,
  output logic                  start_port,
  input  logic                  done_port,
  output logic [1:0]            S_oe_ram,
  output logic [1:0]            S_we_ram,
  output logic [2*ADDR_W-1:0]   S_addr_ram,
  output logic [2*DATA_W-1:0]   S_Wdata_ram,
  output logic [2*SIZE_W-1:0]   S_data_ram_size,
  input  logic [2*DATA_W-1:0]   Sout_Rdata_ram,
  input  logic [1:0]            Sout_DataRdy
);

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_READ   = 2'b01;
  localparam logic [1:0] OP_RUN    = 2'b10;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_BADOP   = 2'b10;

  localparam int              RD_W      = $clog2(RD_TIMEOUT + 1);
  localparam logic [RD_W-1:0] RD_LAST   = RD_W'(RD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RUN_LIMIT = CNT_W'(RUN_TIMEOUT);
  localparam logic [SIZE_W-1:0] ACC_SIZE = SIZE_W'(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_RD      = 3'd2,
    S_RD_WAIT = 3'd3,
    S_START   = 3'd4,
    S_RUN     = 3'd5,
    S_RESP    = 3'd6
  } state_e;

  state_e             state_q;
  logic               cmd_ready_q;
  logic               rsp_valid_q;
  logic [CNT_W-1:0]   rsp_data_q;
  logic [1:0]         rsp_status_q;
  logic               start_q;
  logic               we_q;
  logic               oe_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [SIZE_W-1:0]  size_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [RD_W-1:0]    rd_wait_q;

  logic [CNT_W-1:0]   cnt_inc_d;
  logic [CNT_W-1:0]   rdata_d;
  logic               w_unused_ch1;

  // Saturating increment of the run counter and zero-extended channel-0 read data
  assign cnt_inc_d    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  assign rdata_d      = CNT_W'(Sout_Rdata_ram[DATA_W-1:0]);
  assign w_unused_ch1 = ^{Sout_Rdata_ram[2*DATA_W-1:DATA_W], Sout_DataRdy[1]};

  // Sequencer FSM: every output is a register updated on the edge entering its state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_status_q <= ST_OK;
      start_q      <= 1'b0;
      we_q         <= 1'b0;
      oe_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      size_q       <= '0;
      cnt_q        <= '0;
      rd_wait_q    <= '0;
    end else begin
      // Strobes are single-cycle; only the accept edge raises them
      start_q <= 1'b0;
      we_q    <= 1'b0;
      oe_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          addr_q      <= '0;
          wdata_q     <= '0;
          size_q      <= '0;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            case (cmd_op)
              OP_WRITE: begin
                state_q <= S_WR;
                we_q    <= 1'b1;
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                size_q  <= ACC_SIZE;
              end
              OP_READ: begin
                state_q <= S_RD;
                oe_q    <= 1'b1;
                addr_q  <= cmd_addr;
                size_q  <= ACC_SIZE;
              end
              OP_RUN: begin
                state_q <= S_START;
                start_q <= 1'b1;
                cnt_q   <= CNT_W'(1);
              end
              default: begin
                state_q      <= S_RESP;
                rsp_valid_q  <= 1'b1;
                rsp_data_q   <= '0;
                rsp_status_q <= ST_BADOP;
              end
            endcase
          end
        end
        S_WR: begin
          addr_q       <= '0;
          wdata_q      <= '0;
          size_q       <= '0;
          state_q      <= S_RESP;
          rsp_valid_q  <= 1'b1;
          rsp_data_q   <= '0;
          rsp_status_q <= ST_OK;
        end
        S_RD: begin
          addr_q    <= '0;
          size_q    <= '0;
          rd_wait_q <= '0;
          if (Sout_DataRdy[0]) begin
            state_q      <= S_RESP;
            rsp_valid_q  <= 1'b1;
            rsp_data_q   <= rdata_d;
            rsp_status_q <= ST_OK;
          end else begin
            state_q <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (Sout_DataRdy[0]) begin
            state_q      <= S_RESP;
            rsp_valid_q  <= 1'b1;
            rsp_data_q   <= rdata_d;
            rsp_status_q <= ST_OK;
          end else if (rd_wait_q == RD_LAST) begin
            state_q      <= S_RESP;
            rsp_valid_q  <= 1'b1;
            rsp_data_q   <= '0;
            rsp_status_q <= ST_TIMEOUT;
          end else begin
            rd_wait_q <= rd_wait_q + 1'b1;
          end
        end
        S_START, S_RUN: begin
          // cnt_q already includes the current cycle, so done here reports it directly
          if (done_port) begin
            state_q      <= S_RESP;
            rsp_valid_q  <= 1'b1;
            rsp_data_q   <= cnt_q;
            rsp_status_q <= ST_OK;
          end else if (cnt_q >= RUN_LIMIT) begin
            state_q      <= S_RESP;
            rsp_valid_q  <= 1'b1;
            rsp_data_q   <= RUN_LIMIT;
            rsp_status_q <= ST_TIMEOUT;
          end else begin
            state_q <= S_RUN;
            cnt_q   <= cnt_inc_d;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_q      <= S_IDLE;
            cmd_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_status_q <= ST_OK;
            cnt_q        <= '0;
            rd_wait_q    <= '0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          cmd_ready_q <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Channel 1 is never used by this sequencer and stays tied low
  assign cmd_ready       = cmd_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_data        = rsp_data_q;
  assign rsp_status      = rsp_status_q;
  assign start_port      = start_q;
  assign S_oe_ram        = {1'b0, oe_q};
  assign S_we_ram        = {1'b0, we_q};
  assign S_addr_ram      = {{ADDR_W{1'b0}}, addr_q};
  assign S_Wdata_ram     = {{DATA_W{1'b0}}, wdata_q};
  assign S_data_ram_size = {{SIZE_W{1'b0}}, size_q};

endmodule
`default_nettype wire

// File: tb/tb_hls_run_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hls_run_sequencer
//  Description : Self-checking bench for hls_run_sequencer: table of directed
//                commands plus hand sequences for reset, response back-pressure
//                and run timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hls_run_sequencer;

  logic clock;
  logic reset;
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Main instance (default timeouts)
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, start_port, done_port;
  logic [1:0]  cmd_op, rsp_status, S_oe_ram, S_we_ram, Sout_DataRdy;
  logic [6:0]  cmd_addr;
  logic [7:0]  cmd_wdata, S_data_ram_size;
  logic [31:0] rsp_data;
  logic [13:0] S_addr_ram;
  logic [15:0] S_Wdata_ram, Sout_Rdata_ram;

  // Second instance with a short run timeout
  logic        t_cmd_valid, t_cmd_ready, t_rsp_valid, t_rsp_ready, t_start, t_done;
  logic [1:0]  t_cmd_op, t_rsp_status, t_oe, t_we, t_rdy;
  logic [6:0]  t_cmd_addr;
  logic [7:0]  t_cmd_wdata, t_size;
  logic [31:0] t_rsp_data;
  logic [13:0] t_addr;
  logic [15:0] t_wdata, t_rdata;

  hls_run_sequencer u_dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_status(rsp_status),
    .start_port(start_port), .done_port(done_port),
    .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
    .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
    .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy)
  );

  hls_run_sequencer #(.RUN_TIMEOUT(50)) u_dut_to (
    .clock(clock), .reset(reset),
    .cmd_valid(t_cmd_valid), .cmd_ready(t_cmd_ready), .cmd_op(t_cmd_op),
    .cmd_addr(t_cmd_addr), .cmd_wdata(t_cmd_wdata),
    .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready), .rsp_data(t_rsp_data), .rsp_status(t_rsp_status),
    .start_port(t_start), .done_port(t_done),
    .S_oe_ram(t_oe), .S_we_ram(t_we), .S_addr_ram(t_addr),
    .S_Wdata_ram(t_wdata), .S_data_ram_size(t_size),
    .Sout_Rdata_ram(t_rdata), .Sout_DataRdy(t_rdy)
  );

  typedef struct {
    logic [1:0]  op;
    logic [6:0]  addr;
    logic [7:0]  wd;
    logic [7:0]  rdata;
    int          rd_dly;    // cycle (0 = strobe cycle) DataRdy[0] pulses, -1 never
    int          done_dly;  // cycle (0 = start cycle) done_port pulses, -1 never
    logic [1:0]  e_st;
    logic [31:0] e_data;
    int          e_cyc;     // cycle rsp_valid is first seen
    int          e_we;
    int          e_oe;
    int          e_start;
    logic [13:0] e_addr;
    logic [15:0] e_wdata;
    logic [7:0]  e_size;
  } vec_t;

  typedef struct {
    logic [1:0]  st;
    logic [31:0] data;
    int          cyc, we, oe, start, stray;
    logic [13:0] addr;
    logic [15:0] wdata;
    logic [7:0]  size;
    logic        post_valid, post_ready, timed_out;
  } res_t;

  int checks;
  int errors;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one command, play the slave/accelerator side, observe until the response
  task automatic do_cmd(input vec_t v, output res_t r);
    int  c;
    bit  got;
    r = '{default: '0};
    c = 0;
    while (!cmd_ready && c < 50) begin tick(); c++; end
    cmd_valid = 1'b1; cmd_op = v.op; cmd_addr = v.addr; cmd_wdata = v.wd;
    tick();
    cmd_valid = 1'b0;
    got = 1'b0;
    c = 0;
    while (!got && c < 3000) begin
      if (rsp_valid) begin
        got    = 1'b1;
        r.st   = rsp_status;
        r.data = rsp_data;
        r.cyc  = c;
        if ((S_we_ram | S_oe_ram) != 2'b00 || start_port) r.stray++;
      end else begin
        if (S_we_ram[0] || S_oe_ram[0]) begin
          r.we    += int'(S_we_ram[0]);
          r.oe    += int'(S_oe_ram[0]);
          r.addr  = S_addr_ram;
          r.wdata = S_Wdata_ram;
          r.size  = S_data_ram_size;
        end else if (S_addr_ram != 0 || S_Wdata_ram != 0 || S_data_ram_size != 0) begin
          r.stray++;
        end
        if (start_port) r.start++;
        if (S_we_ram[1] || S_oe_ram[1] || cmd_ready) r.stray++;
        Sout_DataRdy   = {c[0], (v.rd_dly == c)};
        Sout_Rdata_ram = {8'hEE, (v.rd_dly == c) ? v.rdata : 8'h99};
        done_port      = (v.done_dly == c);
        tick();
        c++;
      end
    end
    Sout_DataRdy = 2'b00; Sout_Rdata_ram = '0; done_port = 1'b0;
    r.timed_out = !got;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    r.post_valid = rsp_valid;
    r.post_ready = cmd_ready;
  endtask

  initial begin
    res_t r;
    int   c;
    int   starts;
    checks = 0; errors = 0;

    //         op     addr   wd     rdata  rd  done st     data  cyc we oe st addr      wdata     size
    vecs[0] = '{2'b00, 7'h05, 8'hA7, 8'h00, -1, -1,  2'b00, 32'd0,  1, 1, 0, 0, 14'h0005, 16'h00A7, 8'h08};
    vecs[1] = '{2'b01, 7'h05, 8'h00, 8'h3C,  2, -1,  2'b00, 32'h3C, 3, 0, 1, 0, 14'h0005, 16'h0000, 8'h08};
    vecs[2] = '{2'b01, 7'h7F, 8'h00, 8'hA5,  0, -1,  2'b00, 32'hA5, 1, 0, 1, 0, 14'h007F, 16'h0000, 8'h08};
    vecs[3] = '{2'b01, 7'h12, 8'h00, 8'h00, -1, -1,  2'b01, 32'd0, 17, 0, 1, 0, 14'h0012, 16'h0000, 8'h08};
    vecs[4] = '{2'b01, 7'h12, 8'h00, 8'h5A, 16, -1,  2'b00, 32'h5A,17, 0, 1, 0, 14'h0012, 16'h0000, 8'h08};
    vecs[5] = '{2'b10, 7'h00, 8'h00, 8'h00, -1,  0,  2'b00, 32'd1,  1, 0, 0, 1, 14'h0000, 16'h0000, 8'h00};
    vecs[6] = '{2'b10, 7'h33, 8'h44, 8'h00, -1, 1000,2'b00, 32'd1001,1001,0,0,1,14'h0000, 16'h0000, 8'h00};
    vecs[7] = '{2'b11, 7'h05, 8'hA7, 8'h00, -1, -1,  2'b10, 32'd0,  0, 0, 0, 0, 14'h0000, 16'h0000, 8'h00};
    vecs[8] = '{2'b00, 7'h7F, 8'hFF, 8'h00, -1, -1,  2'b00, 32'd0,  1, 1, 0, 0, 14'h007F, 16'h00FF, 8'h08};
    vecs[9] = '{2'b01, 7'h01, 8'h00, 8'h00, -1,  0,  2'b01, 32'd0, 17, 0, 1, 0, 14'h0001, 16'h0000, 8'h08};

    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 7'h05; cmd_wdata = 8'hA7;
    rsp_ready = 1'b0; done_port = 1'b0; Sout_DataRdy = 2'b00; Sout_Rdata_ram = '0;
    t_cmd_valid = 1'b1; t_cmd_op = 2'b00; t_cmd_addr = 7'h05; t_cmd_wdata = 8'hA7;
    t_rsp_ready = 1'b0; t_done = 1'b0; t_rdy = 2'b00; t_rdata = '0;
    reset = 1'b0;

    // Reset held with a command pending: everything stays low
    repeat (3) begin
      tick();
      chk("reset_ctl", {cmd_ready, rsp_valid, rsp_status, start_port, S_oe_ram, S_we_ram}, 0);
      chk("reset_data", rsp_data, 0);
      chk("reset_slave", {S_addr_ram, S_Wdata_ram, S_data_ram_size}, 0);
    end
    chk("reset_t", {t_cmd_ready, t_rsp_valid, t_start, t_we}, 0);
    reset = 1'b1;
    tick();
    chk("ready_after_release", cmd_ready, 1'b1);
    chk("no_accept_in_reset", {S_we_ram, rsp_valid}, 0);
    chk("ready_after_release_t", t_cmd_ready, 1'b1);
    cmd_valid = 1'b0; t_cmd_valid = 1'b0;

    // Directed command table
    foreach (vecs[i]) begin
      do_cmd(vecs[i], r);
      chk($sformatf("v%0d_no_hang", i), r.timed_out, 1'b0);
      chk($sformatf("v%0d_status", i), r.st, vecs[i].e_st);
      chk($sformatf("v%0d_data", i), r.data, vecs[i].e_data);
      chk($sformatf("v%0d_rsp_cycle", i), r.cyc, vecs[i].e_cyc);
      chk($sformatf("v%0d_strobes", i), {r.we[7:0], r.oe[7:0], r.start[7:0]},
          {vecs[i].e_we[7:0], vecs[i].e_oe[7:0], vecs[i].e_start[7:0]});
      chk($sformatf("v%0d_slave_fields", i), {r.addr, r.wdata, r.size},
          {vecs[i].e_addr, vecs[i].e_wdata, vecs[i].e_size});
      chk($sformatf("v%0d_stray", i), r.stray, 0);
      chk($sformatf("v%0d_handshake", i), {r.post_valid, r.post_ready}, 2'b01);
    end

    // BADOP with response back-pressure
    cmd_valid = 1'b1; cmd_op = 2'b11;
    tick();
    cmd_valid = 1'b0;
    repeat (5) begin
      chk("hold_rsp", {rsp_valid, rsp_status, cmd_ready}, {1'b1, 2'b10, 1'b0});
      tick();
    end
    chk("hold_rsp_last", {rsp_valid, rsp_status, cmd_ready}, {1'b1, 2'b10, 1'b0});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("hold_release", {rsp_valid, cmd_ready}, 2'b01);

    // Run timeout on the short-timeout instance, then a normal WRITE
    t_cmd_valid = 1'b1; t_cmd_op = 2'b10;
    tick();
    t_cmd_valid = 1'b0;
    c = 0; starts = 0;
    while (!t_rsp_valid && c < 200) begin
      if (t_start) starts++;
      tick();
      c++;
    end
    chk("to_rsp_cycle", c, 50);
    chk("to_status", t_rsp_status, 2'b01);
    chk("to_data", t_rsp_data, 32'd50);
    chk("to_starts", starts, 1);
    t_rsp_ready = 1'b1;
    tick();
    t_rsp_ready = 1'b0;
    chk("to_idle", {t_rsp_valid, t_cmd_ready}, 2'b01);
    t_cmd_valid = 1'b1; t_cmd_op = 2'b00; t_cmd_addr = 7'h05; t_cmd_wdata = 8'hA7;
    tick();
    t_cmd_valid = 1'b0;
    chk("to_wr_strobe", {t_we, t_addr, t_wdata, t_size}, {2'b01, 14'h0005, 16'h00A7, 8'h08});
    tick();
    chk("to_wr_rsp", {t_rsp_valid, t_rsp_status, t_we}, {1'b1, 2'b00, 2'b00});
    t_rsp_ready = 1'b1;
    tick();
    t_rsp_ready = 1'b0;

    // Reset in the middle of a run aborts without a response
    cmd_valid = 1'b1; cmd_op = 2'b10;
    tick();
    cmd_valid = 1'b0;
    chk("run_start_pulse", start_port, 1'b1);
    repeat (5) tick();
    chk("run_busy", {start_port, rsp_valid, cmd_ready}, 3'b000);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_outs", {start_port, rsp_valid, cmd_ready}, 3'b000);
    chk("async_reset_data", rsp_data, 0);
    tick();
    reset = 1'b1;
    tick();
    chk("after_abort", {rsp_valid, cmd_ready}, 2'b01);
    do_cmd('{2'b10, 7'h00, 8'h00, 8'h00, -1, 3, 2'b00, 32'd4, 4, 0, 0, 1, 14'h0, 16'h0, 8'h0}, r);
    chk("rerun_data", {r.st, r.data}, {2'b00, 32'd4});
    chk("rerun_cycle", r.cyc, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
